// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 set-2 scan-code sequencer.
//   - scan-code constants for the prefixes and status bytes
//   - sequencer state encoding
//   - packed key-event record {brk, ext, code}
package ps2_pkg;

  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] PS2_PAUSE    = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_OVR0     = 8'h00;
  localparam logic [7:0] PS2_OVR1     = 8'hFF;

  // Code reported for the whole E1 Pause sequence
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_PAUSE
  } seq_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_ev_t;

  localparam int EV_W = $bits(ps2_ev_t);

  // Keyboard error/overrun codes
  function automatic logic is_err_code(input logic [7:0] b);
    return (b == PS2_BAT_FAIL) || (b == PS2_OVR0) || (b == PS2_OVR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO for key events.
//   sysclk/reset : clock, synchronous active-high reset (pointers only)
//   push/wdata   : write request; accepted when not full, or when full and
//                  a pop happens in the same cycle
//   pop          : read request; ignored when empty
//   rdata        : head entry, forced to zero while empty
//   full/empty   : occupancy flags
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty
  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; visibility is governed by the pointers
  always_ff @(posedge sysclk) begin
    if (do_push && !reset) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_keyseq.sv
// ps2_keyseq: folds PS/2 set-2 byte sequences into key events.
//   sysclk, reset          : clock, synchronous active-high reset
//   word, done             : byte from parser with one-cycle strobe
//   ev_valid/ev_ready      : head-of-queue handshake
//   ev_code/ev_ext/ev_brk  : head event fields (zero while empty)
//   bat_ok                 : one-cycle pulse on self-test pass (AA)
//   kbd_err                : sticky, FC/00/FF seen
//   ovf                    : sticky, event dropped on full queue
//   err_clr                : clears kbd_err and ovf (a same-cycle set wins)
module ps2_keyseq
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] word,
  input  logic       done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       bat_ok,
  output logic       kbd_err,
  output logic       ovf,
  input  logic       err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e state;
  logic       ext_f;
  logic [2:0] skip_cnt;
  logic [TW-1:0] tmo_cnt;

  logic    push, pop, full, empty;
  logic    bat_set, err_set, ovf_set;
  ps2_ev_t push_ev, head;

  // Event generation is combinational so the FIFO write lands on the
  // same edge that samples done.
  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    bat_set = 1'b0;
    err_set = 1'b0;
    if (done) begin
      unique case (state)
        ST_IDLE: begin
          if (word == PS2_BAT_OK)   bat_set = 1'b1;
          else if (is_err_code(word)) err_set = 1'b1;
          else if (word != PS2_EXT && word != PS2_BRK && word != PS2_PAUSE) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, ext: 1'b0, code: word};
          end
        end
        ST_EXT: if (word != PS2_BRK) begin
          push    = 1'b1;
          push_ev = '{brk: 1'b0, ext: 1'b1, code: word};
        end
        ST_BRK: begin
          push    = 1'b1;
          push_ev = '{brk: 1'b1, ext: ext_f, code: word};
        end
        ST_PAUSE: if (skip_cnt <= 3'd1) begin
          push    = 1'b1;
          push_ev = '{brk: 1'b0, ext: 1'b1, code: PS2_PAUSE_CODE};
        end
        default: ;
      endcase
    end
  end

  assign pop     = ev_ready & ev_valid;
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ext_f    <= 1'b0;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
      bat_ok   <= 1'b0;
      kbd_err  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      bat_ok <= bat_set;
      if (done) begin
        tmo_cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (word == PS2_EXT) begin
              state <= ST_EXT;
              ext_f <= 1'b1;
            end else if (word == PS2_BRK) begin
              state <= ST_BRK;
              ext_f <= 1'b0;
            end else if (word == PS2_PAUSE) begin
              state    <= ST_PAUSE;
              skip_cnt <= 3'd7;
            end
          end
          ST_EXT: begin
            if (word == PS2_BRK) state <= ST_BRK;
            else begin
              state <= ST_IDLE;
              ext_f <= 1'b0;
            end
          end
          ST_BRK: begin
            state <= ST_IDLE;
            ext_f <= 1'b0;
          end
          ST_PAUSE: begin
            // Pause payload bytes are counted, never decoded
            if (skip_cnt <= 3'd1) begin
              state    <= ST_IDLE;
              skip_cnt <= '0;
            end else begin
              skip_cnt <= skip_cnt - 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // Stalled partial sequence: abandon silently
        if (tmo_cnt == TW'(TIMEOUT)) begin
          state    <= ST_IDLE;
          ext_f    <= 1'b0;
          skip_cnt <= '0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
      if (err_set)      kbd_err <= 1'b1;
      else if (err_clr) kbd_err <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
    end
  end

  ps2_event_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push),
    .wdata  (push_ev),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign ev_valid = ~empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_brk   = head.brk;

endmodule

// File: tb/tb_ps2_keyseq.sv
// tb_ps2_keyseq: directed plus randomized key-sequence stimulus. Expected
// events come from the key being typed (kind + code), not from byte-level
// decoding, and are kept in a queue compared against the FIFO head.
module tb_ps2_keyseq;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 2000;

  logic       sysclk = 1'b0;
  logic       reset, done, ev_ready, err_clr;
  logic [7:0] word;
  logic       ev_valid, ev_ext, ev_brk, bat_ok, kbd_err, ovf;
  logic [7:0] ev_code;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];

  always #5 sysclk = ~sysclk;

  ps2_keyseq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .word     (word),
    .done     (done),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .bat_ok   (bat_ok),
    .kbd_err  (kbd_err),
    .ovf      (ovf),
    .err_clr  (err_clr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic b, input logic e, input logic [7:0] c);
    return {b, e, c};
  endfunction

  // Ordinary key code: none of the prefix/status bytes
  function automatic logic [7:0] rnd_code();
    logic [7:0] c;
    do c = 8'($urandom_range(1, 254));
    while (c == 8'hE0 || c == 8'hF0 || c == 8'hE1 || c == 8'hAA || c == 8'hFC);
    return c;
  endfunction

  // One byte, one cycle of done; starts and ends at a negedge
  task automatic send(input logic [7:0] b);
    word = b;
    done = 1'b1;
    @(negedge sysclk);
    done = 1'b0;
  endtask

  // kind: 0 make, 1 break, 2 ext make, 3 ext break, 4 pause
  task automatic key(input int kind, input logic [7:0] c);
    case (kind)
      0: begin send(c); exp_q.push_back(mk(0, 0, c)); end
      1: begin send(8'hF0); send(c); exp_q.push_back(mk(1, 0, c)); end
      2: begin send(8'hE0); send(c); exp_q.push_back(mk(0, 1, c)); end
      3: begin send(8'hE0); send(8'hF0); send(c); exp_q.push_back(mk(1, 1, c)); end
      default: begin
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        exp_q.push_back(mk(0, 1, 8'h77));
      end
    endcase
  endtask

  // Consume everything expected; random_rdy throttles the consumer
  task automatic drain(input string tag, input bit random_rdy);
    int guard = 0;
    logic rdy;
    while (exp_q.size() > 0 && guard < 300) begin
      if (ev_valid) begin
        chk(tag, {6'd0, ev_brk, ev_ext, ev_code}, {6'd0, exp_q[0]});
        rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy) void'(exp_q.pop_front());
      end else begin
        rdy = 1'b0;
      end
      ev_ready = rdy;
      @(negedge sysclk);
      guard++;
    end
    ev_ready = 1'b0;
    chk({tag, "_left"}, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    chk({tag, "_empty"}, {15'd0, ev_valid}, 16'd0);
  endtask

  initial begin
    logic [7:0] c;
    int n;
    reset = 1'b1; done = 1'b0; word = 8'h00; ev_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_flags", {12'd0, ev_valid, bat_ok, kbd_err, ovf}, 16'd0);
    chk("rst_head", {6'd0, ev_brk, ev_ext, ev_code}, 16'd0);
    reset = 1'b0;
    @(negedge sysclk);

    // Make then break, with one-cycle latency on ev_valid
    send(8'h1C);
    chk("make_lat", {15'd0, ev_valid}, 16'd1);
    exp_q.push_back(mk(0, 0, 8'h1C));
    drain("make", 0);
    send(8'hF0);
    chk("brk_prefix_noev", {15'd0, ev_valid}, 16'd0);
    send(8'h1C);
    chk("brk_lat", {15'd0, ev_valid}, 16'd1);
    exp_q.push_back(mk(1, 0, 8'h1C));
    drain("break", 0);

    key(3, 8'h75); drain("ext_break", 0);
    key(2, 8'h75); drain("ext_make", 0);
    key(4, 8'h00); drain("pause", 0);

    // Abandoned E0 prefix
    send(8'hE0);
    repeat (TIMEOUT + 5) @(negedge sysclk);
    chk("tmo_noev", {15'd0, ev_valid}, 16'd0);
    key(0, 8'h1C); drain("after_tmo", 0);

    // Overflow: DEPTH+1 makes with no consumer, last one dropped
    for (int i = 0; i <= DEPTH; i++) begin
      c = rnd_code();
      send(c);
      if (i < DEPTH) exp_q.push_back(mk(0, 0, c));
    end
    chk("ovf_set", {15'd0, ovf}, 16'd1);
    drain("ovf_keep", 0);
    chk("ovf_sticky", {15'd0, ovf}, 16'd1);
    err_clr = 1'b1; @(negedge sysclk); err_clr = 1'b0;
    chk("ovf_clr", {15'd0, ovf}, 16'd0);

    // Full queue: push and pop together must not overflow
    for (int i = 0; i < DEPTH; i++) key(0, rnd_code());
    chk("full_noovf", {15'd0, ovf}, 16'd0);
    chk("full_head", {6'd0, ev_brk, ev_ext, ev_code}, {6'd0, exp_q[0]});
    c = rnd_code();
    word = c; done = 1'b1; ev_ready = 1'b1;
    @(negedge sysclk);
    done = 1'b0; ev_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(mk(0, 0, c));
    chk("pushpop_noovf", {15'd0, ovf}, 16'd0);
    drain("pushpop", 0);

    // Status bytes
    send(8'hAA);
    chk("bat_pulse", {15'd0, bat_ok}, 16'd1);
    @(negedge sysclk);
    chk("bat_once", {15'd0, bat_ok}, 16'd0);
    chk("bat_noev", {15'd0, ev_valid}, 16'd0);
    send(8'hFC);
    chk("kerr_set", {15'd0, kbd_err}, 16'd1);
    chk("kerr_noev", {15'd0, ev_valid}, 16'd0);
    err_clr = 1'b1; @(negedge sysclk); err_clr = 1'b0;
    chk("kerr_clr", {15'd0, kbd_err}, 16'd0);
    send(8'hFF);
    chk("kerr_ff", {15'd0, kbd_err}, 16'd1);
    err_clr = 1'b1; @(negedge sysclk); err_clr = 1'b0;

    // Reset discards queued events and a half-done break
    send(8'h2A);
    reset = 1'b1; @(negedge sysclk); reset = 1'b0;
    chk("rst_flush", {15'd0, ev_valid}, 16'd0);
    send(8'hF0);
    reset = 1'b1; @(negedge sysclk); reset = 1'b0;
    key(0, 8'h1C); drain("rst_midseq", 0);

    // Randomized key streams with a throttled consumer
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        key($urandom_range(0, 4), rnd_code());
        repeat ($urandom_range(0, 3)) @(negedge sysclk);
      end
      drain("rand", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyseq.md
# ps2_keyseq

Scan-code sequencer sitting directly behind the PS/2 byte parser. Consumes each completed byte (`word` with a one-cycle `done` strobe), folds the multi-byte PS/2 set-2 sequences (E0 extended prefix, F0 break prefix, the 8-byte E1 Pause sequence) into single key events, and queues the events in a small FIFO for the host logic. Also flags keyboard self-test results, overrun codes and FIFO overflow.

## Interface
- `DEPTH`, 8, event FIFO depth; power of two, minimum 2.
- `TIMEOUT`, 2000, sysclk cycles allowed between bytes of one sequence before the partial sequence is discarded.

- `sysclk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `word`  in  8  byte from parser, valid only when `done`=1.
- `done`  in  1  one-cycle strobe: `word` is a complete, parity-checked byte.
- `ev_valid`  out  1  head-of-FIFO event present.
- `ev_ready`  in  1  consumer accepts the head event this cycle.
- `ev_code`  out  8  key code of head event.
- `ev_ext`  out  1  event was E0-prefixed (or Pause).
- `ev_brk`  out  1  event is a release (F0-prefixed).
- `bat_ok`  out  1  one-cycle pulse on receipt of 0xAA in IDLE.
- `kbd_err`  out  1  sticky: 0xFC, 0x00 or 0xFF received.
- `ovf`  out  1  sticky: an event was dropped because the FIFO was full.
- `err_clr`  in  1  clears `kbd_err` and `ovf`.

## Operation
- Sequencer states: IDLE, EXT, BRK, PAUSE. Registers `ext_f`, `skip_cnt` (3 bits), `tmo_cnt` ($clog2(TIMEOUT+1) bits).
- IDLE, byte in:
  - E0 -> EXT, `ext_f`=1.
  - F0 -> BRK, `ext_f`=0.
  - E1 -> PAUSE, `skip_cnt`=7.
  - AA -> pulse `bat_ok`.
  - FC/00/FF -> set `kbd_err`.
  - Anything else -> push {brk=0, ext=0, code}.
- EXT, byte in:
  - F0 -> BRK, `ext_f` kept at 1.
  - Other -> push {0, 1, code}; go IDLE.
- BRK, byte in: push {1, `ext_f`, code}; go IDLE.
- PAUSE, byte in: decrement `skip_cnt`. At 0, push {0, 1, 8'h77}; go IDLE. The 7 following bytes are never decoded.
- `tmo_cnt` clears on every `done` and on entry to IDLE, and increments each cycle while not IDLE. On reaching TIMEOUT: go IDLE, clear `ext_f`, push nothing.
- FIFO:
  - Push when full and no pop -> event dropped, `ovf`=1.
  - Push and pop in the same cycle when full -> both occur, no overflow.
  - Pop when empty is ignored.
  - Pointers are $clog2(DEPTH)+1 bits and wrap naturally. Empty when pointers are equal; full when the MSBs differ and the rest are equal.
- `err_clr` and a same-cycle set event: set wins.

## Timing
- Reset values: state IDLE; `ext_f`, `skip_cnt`, `tmo_cnt` = 0; FIFO empty; `ev_valid`, `bat_ok`, `kbd_err`, `ovf` = 0; `ev_code`, `ev_ext`, `ev_brk` = 0.
- `done` sampled at edge N -> state update and FIFO write at N. `ev_valid` rises after edge N if the FIFO was empty (one-cycle latency). `bat_ok` is high for the cycle after N.
- Handshake: the head event is transferred on any edge where `ev_valid` & `ev_ready`. Head outputs are stable while `ev_valid` & !`ev_ready`.
- `reset` mid-sequence or with the FIFO non-empty discards everything in the next cycle, regardless of `done`.
- `done` on two consecutive cycles: both bytes are processed in order. No back-pressure to the parser.

## Structure
- Package `ps2_pkg`:
  - Code constants `PS2_EXT`=E0, `PS2_BRK`=F0, `PS2_PAUSE`=E1, `PS2_BAT_OK`=AA, `PS2_BAT_FAIL`=FC, `PS2_OVR0`=00, `PS2_OVR1`=FF.
  - Sequencer state enum.
  - Packed event struct {brk, ext, code}, 10 bits.
- Sub-module `ps2_event_fifo`: parameterised synchronous FIFO (DEPTH, width 10) with push/pop/full/empty. The sequencer instantiates it, and `ovf` is derived as push & full & !pop.

## Test plan
- Bytes 1C, then F0 1C, with `ev_ready`=1 -> events {0,0,1C}, then {1,0,1C}. `ev_valid` goes high one cycle after each final `done`.
- E0 F0 75 -> single event {1,1,75}. E0 75 -> {0,1,75}.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {0,1,77}. No event for the inner 14/77.
- E0, then no byte for TIMEOUT cycles, then 1C -> event {0,0,1C}, not extended.
- `ev_ready`=0, DEPTH+1 make codes -> first DEPTH events retained in order, `ovf`=1. Then `err_clr` -> `ovf`=0. A push and pop in the same cycle while full sets no `ovf`.
- AA -> one-cycle `bat_ok`, no event. FC -> `kbd_err`=1, no event. `reset` asserted after F0 -> next byte 1C yields {0,0,1C}.
